// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector: Moore FSM with KMP fallback transitions
// and optional saturating match counter (enabled by defining SEQDET_MATCH_CNT_EN).
module seq_detector_param #(
    parameter int          SEQ_LEN     = 4,
    parameter logic [15:0] SEQ_PATTERN = 16'h000B,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [4:0]       progress,
    output logic [CNT_W-1:0] match_cnt
);

    typedef logic [4:0] state_t;

    localparam state_t MATCH_ST = state_t'(SEQ_LEN);

    // Pattern bit j in arrival order (j = 0 is received first).
    function automatic logic pat_bit(input int j);
        return SEQ_PATTERN[SEQ_LEN-1-j];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    function automatic state_t kmp_step(input int k, input logic b);
        logic [15:0] s;
        logic        ok;
        int          best;
        s = '0;
        for (int j = 0; j < 16; j++)
            if (j < k) s[j] = pat_bit(j);
        s[k] = b;
        best = 0;
        for (int l = 1; l <= 16; l++) begin
            if (l <= k + 1) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++)
                    if (j < l && pat_bit(j) != s[k+1-l+j]) ok = 1'b0;
                if (ok) best = l;
            end
        end
        return state_t'(best);
    endfunction

    // Longest proper prefix of the whole pattern that is also its suffix.
    function automatic state_t border_len();
        logic ok;
        int   best;
        best = 0;
        for (int l = 1; l < 16; l++) begin
            if (l < SEQ_LEN) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++)
                    if (j < l && pat_bit(j) != pat_bit(SEQ_LEN-l+j)) ok = 1'b0;
                if (ok) best = l;
            end
        end
        return state_t'(best);
    endfunction

    function automatic logic [79:0] build_tab(input logic b);
        logic [79:0] tab;
        tab = '0;
        for (int k = 0; k < 16; k++)
            if (k < SEQ_LEN) tab[k*5 +: 5] = kmp_step(k, b);
        return tab;
    endfunction

    localparam logic [79:0] TAB0      = build_tab(1'b0);
    localparam logic [79:0] TAB1      = build_tab(1'b1);
    localparam state_t      BORDER_ST = border_len();

    state_t state, state_n, src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= '0;
        else     state <= state_n;
    end

    // Leaving MATCH reuses the row of S0 or of the border state.
    always_comb begin
        state_n = state;
        src     = state;
        if (state == MATCH_ST) src = overlap ? BORDER_ST : '0;
        if (en) state_n = din ? TAB1[int'(src)*5 +: 5] : TAB0[int'(src)*5 +: 5];
    end

    assign match    = (state == MATCH_ST);
    assign progress = state;

`ifdef SEQDET_MATCH_CNT_EN
    logic             enter_match;
    logic [CNT_W-1:0] cnt;

    assign enter_match = en && (state_n == MATCH_ST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr_cnt)
            cnt <= enter_match ? CNT_W'(1) : '0;
        else if (enter_match && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

    assign match_cnt = cnt;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (pattern 1011); counter expectations
// follow whether SEQDET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       overlap = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       match_a, match_b;
    logic [4:0] progress_a, progress_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match_a), .progress(progress_a), .match_cnt(cnt_a)
    );

    seq_detector_param #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .clr_cnt(clr_cnt),
        .match(match_b), .progress(progress_b), .match_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic d, input logic e);
        @(negedge clk);
        din = d;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic d, input logic [4:0] exp_prog);
        step(d, 1'b1);
        chk({tag, " progress"}, {27'd0, progress_a}, {27'd0, exp_prog});
        chk({tag, " match"}, {31'd0, match_a}, {31'd0, exp_prog == 5'd4});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset match", {31'd0, match_a}, 32'd0);
        chk("reset progress", {27'd0, progress_a}, 32'd0);
        chk("reset cnt", {24'd0, cnt_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-overlapping: 1,0,1,1,0,1,1
        overlap = 1'b0;
        step_chk("nov b1", 1'b1, 5'd1);
        step_chk("nov b2", 1'b0, 5'd2);
        step_chk("nov b3", 1'b1, 5'd3);
        step_chk("nov b4", 1'b1, 5'd4);
        step_chk("nov b5", 1'b0, 5'd0);
        step_chk("nov b6", 1'b1, 5'd1);
        step_chk("nov b7", 1'b1, 5'd1);
        chk("nov cnt", {24'd0, cnt_a}, CNT_ON ? 32'd1 : 32'd0);

        // Overlapping: same stream, second match reuses the trailing 1
        do_reset();
        overlap = 1'b1;
        step_chk("ov b1", 1'b1, 5'd1);
        step_chk("ov b2", 1'b0, 5'd2);
        step_chk("ov b3", 1'b1, 5'd3);
        step_chk("ov b4", 1'b1, 5'd4);
        step_chk("ov b5", 1'b0, 5'd2);
        step_chk("ov b6", 1'b1, 5'd3);
        step_chk("ov b7", 1'b1, 5'd4);
        chk("ov cnt", {24'd0, cnt_a}, CNT_ON ? 32'd2 : 32'd0);

        // KMP fallback: 1,0,1,0,1,1
        do_reset();
        overlap = 1'b0;
        step_chk("kmp b1", 1'b1, 5'd1);
        step_chk("kmp b2", 1'b0, 5'd2);
        step_chk("kmp b3", 1'b1, 5'd3);
        step_chk("kmp b4", 1'b0, 5'd2);
        step_chk("kmp b5", 1'b1, 5'd3);
        step_chk("kmp b6", 1'b1, 5'd4);
        chk("kmp cnt", {24'd0, cnt_a}, CNT_ON ? 32'd1 : 32'd0);

        // Stall with en=0 (din/overlap wiggling), then the final bit
        do_reset();
        step_chk("hold b1", 1'b1, 5'd1);
        step_chk("hold b2", 1'b0, 5'd2);
        step_chk("hold b3", 1'b1, 5'd3);
        for (int i = 0; i < 5; i++) begin
            overlap = i[0];
            step(i[1], 1'b0);
            chk("hold progress", {27'd0, progress_a}, 32'd3);
            chk("hold match", {31'd0, match_a}, 32'd0);
        end
        overlap = 1'b0;
        step_chk("hold b4", 1'b1, 5'd4);
        // Overlap changes while parked in MATCH are irrelevant; only the leaving edge samples it
        overlap = 1'b1;
        step(1'b1, 1'b0);
        chk("match held", {31'd0, match_a}, 32'd1);
        overlap = 1'b0;
        step_chk("leave nov", 1'b0, 5'd0);

        // Asynchronous reset mid-sequence
        do_reset();
        step_chk("arst b1", 1'b1, 5'd1);
        step_chk("arst b2", 1'b0, 5'd2);
        step_chk("arst b3", 1'b1, 5'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst progress", {27'd0, progress_a}, 32'd0);
        chk("arst match", {31'd0, match_a}, 32'd0);
        chk("arst cnt", {24'd0, cnt_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step_chk("arst next", 1'b1, 5'd1);

        // Five overlapped matches: 2-bit counter saturates at 3
        do_reset();
        overlap = 1'b1;
        step_chk("sat b1", 1'b1, 5'd1);
        step_chk("sat b2", 1'b0, 5'd2);
        step_chk("sat b3", 1'b1, 5'd3);
        step_chk("sat b4", 1'b1, 5'd4);
        for (int i = 0; i < 4; i++) begin
            step_chk("sat r0", 1'b0, 5'd2);
            step_chk("sat r1", 1'b1, 5'd3);
            step_chk("sat r2", 1'b1, 5'd4);
        end
        chk("sat cnt2", {30'd0, cnt_b}, CNT_ON ? 32'd3 : 32'd0);
        chk("sat cnt8", {24'd0, cnt_a}, CNT_ON ? 32'd5 : 32'd0);
        chk("sat match2", {31'd0, match_b}, 32'd1);

        // clr_cnt coinciding with MATCH entry loads 1
        step_chk("clr b1", 1'b0, 5'd2);
        step_chk("clr b2", 1'b1, 5'd3);
        clr_cnt = 1'b1;
        step_chk("clr b3", 1'b1, 5'd4);
        clr_cnt = 1'b0;
        chk("clr cnt2", {30'd0, cnt_b}, CNT_ON ? 32'd1 : 32'd0);
        chk("clr cnt8", {24'd0, cnt_a}, CNT_ON ? 32'd1 : 32'd0);

        // clr_cnt without a match zeroes the count
        clr_cnt = 1'b1;
        step_chk("clr0 b1", 1'b0, 5'd2);
        clr_cnt = 1'b0;
        chk("clr0 cnt8", {24'd0, cnt_a}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL provide parameter SEQ_LEN, default 4, pattern length in bits; legal range 2..16.
REQ-002 SHALL provide parameter SEQ_PATTERN [15:0], default 16'h000B, target pattern in bits [SEQ_LEN-1:0], bit SEQ_LEN-1 received first; upper bits ignored.
REQ-003 SHALL provide parameter CNT_W, default 8, match counter width; legal range 1..32.
REQ-004 SHALL provide port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL provide port en  input  1  sample strobe; din consumed only on edges with en=1.
REQ-007 SHALL provide port din  input  1  serial data bit.
REQ-008 SHALL provide port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL provide port clr_cnt  input  1  synchronous clear of match_cnt.
REQ-010 SHALL provide port match  output  1  Moore output; high while FSM is in MATCH state.
REQ-011 SHALL provide port progress  output  5  current state index 0..SEQ_LEN; zero-extended.
REQ-012 SHALL provide port match_cnt  output  CNT_W  saturating count of detected matches.

Function
REQ-013 SHALL implement a Moore FSM with states S0..S(SEQ_LEN-1) and MATCH (index SEQ_LEN); Sk = first k pattern bits received.
REQ-014 SHALL, on an edge with en=1 in state Sk, move to S(k+1) (MATCH if k+1=SEQ_LEN) when din equals pattern bit SEQ_LEN-1-k.
REQ-015 SHALL, on mismatch in Sk, move to the longest proper pattern prefix that is a suffix of received prefix plus din (KMP failure transition), never unconditionally to S0.
REQ-016 SHALL, on an edge with en=1 in MATCH and overlap=0, take the transition S0 would take for din.
REQ-017 SHALL, on an edge with en=1 in MATCH and overlap=1, take the transition of state F for din, F = longest proper prefix of the pattern that is also its suffix.
REQ-018 SHALL sample overlap only on edges leaving MATCH; changes elsewhere have no effect.
REQ-019 SHALL hold state, match and progress on edges with en=0.
REQ-020 SHALL drive match purely from state (no combinational path from din, en or overlap); match rises on the edge that samples the final pattern bit, zero extra latency.
REQ-021 SHALL compute all transition tables from parameters at elaboration; no runtime pattern loading.

Reset
REQ-022 SHALL, while rst=1, force state S0, match=0, progress=0, match_cnt=0 independently of clk.
REQ-023 SHALL discard any partial progress when rst asserts mid-sequence; detection restarts from S0 on the first en edge after release.

Configuration
REQ-024 SHALL use macro SEQDET_MATCH_CNT_EN to select counter logic.
REQ-025 SHALL, with SEQDET_MATCH_CNT_EN defined, increment match_cnt on every edge entering MATCH, saturating at all-ones.
REQ-026 SHALL, with SEQDET_MATCH_CNT_EN defined, zero match_cnt on an edge with clr_cnt=1; simultaneous clr_cnt and MATCH entry loads 1.
REQ-027 SHALL, without SEQDET_MATCH_CNT_EN, tie match_cnt to 0, ignore clr_cnt, and instantiate no counter flops; FSM behaviour unchanged.

Verification
REQ-028 SHALL cover: defaults, overlap=0, en=1, din 1,0,1,1,0,1,1 -> match high one cycle after 4th bit only; match_cnt=1.
REQ-029 SHALL cover: same stream, overlap=1 -> match high after 4th and 7th bits; match_cnt=2.
REQ-030 SHALL cover: din 1,0,1,0,1,1 -> progress 1,2,3,2,3,MATCH(4); single match, proves KMP fallback.
REQ-031 SHALL cover: din 1,0,1 then en=0 for 5 cycles, then en=1 din 1 -> progress holds 3, then match.
REQ-032 SHALL cover: rst pulse mid-clock after 1,0,1 -> progress=0 immediately, next 1 gives progress=1, no match.
REQ-033 SHALL cover: CNT_W=2, macro defined, 5 overlapped matches -> match_cnt saturates at 3; clr_cnt with MATCH entry -> 1; macro undefined -> match_cnt stays 0.
